mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Sequencer that drives one `MultAddUnitFloat16` MAC lane.
- Fetches `len` FP16 operand pairs from two synchronous-read buffers (weight and feature) and streams them to the MAC one pair per clock.
- Controls the MAC's reset so every job starts from a zero accumulator.
- Captures the MAC result on its ready pulse and presents it downstream on a valid/ready handshake.
- Sits between the layer controller and each MAC lane in the convolution datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 16, FP16 operand/result width
- `ADDR_WIDTH`, 10, buffer address width
- `CLK_NUM_WIDTH`, 8, width of `len` and `mac_clk_num`
- `TIMEOUT`, 64, maximum WAIT cycles before a timeout error

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  job request, sampled only in IDLE
- `len`  in  CLK_NUM_WIDTH  number of operand pairs; latched on an accepted start
- `a_base`, `b_base`  in  ADDR_WIDTH  start addresses; latched on an accepted start
- `busy`  out  1  high whenever state != IDLE
- `a_rd_en`, `b_rd_en`  out  1  buffer read enables
- `a_rd_addr`, `b_rd_addr`  out  ADDR_WIDTH  buffer read addresses
- `a_rd_data`, `b_rd_data`  in  DATA_WIDTH  read data, valid 1 cycle after the enable
- `mac_rst`  out  1  active-low reset to the MAC
- `mac_a`, `mac_b`  out  DATA_WIDTH  registered operands to the MAC
- `mac_clk_num`  out  CLK_NUM_WIDTH  equals latched `len`
- `mac_result_ready`  in  1  MAC result pulse
- `mac_result`  in  DATA_WIDTH  MAC result
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accept
- `out_data`  out  DATA_WIDTH  captured result
- `err_timeout`  out  1  sticky timeout flag; cleared on the next accepted start

## Operation
States: IDLE, FETCH, DRAIN, WAIT, HOLD.

- **Reset values** (while `rst`=0): state IDLE; `busy`, `a_rd_en`, `b_rd_en`, `out_valid`, `err_timeout` = 0; all addresses, `mac_a`, `mac_b`, `mac_clk_num`, `out_data` = 0; `mac_rst` = 0 (MAC held in reset).
- **IDLE:**
  - `mac_rst`=0.
  - `start`=1 with `len`≠0 → latch `len`, `a_base`, `b_base`; clear `err_timeout`; go to FETCH.
  - `start`=1 with `len`=0 → `out_data`=16'h0000, go to HOLD; no buffer reads, no MAC activity.
- **FETCH:**
  - Issue reads for i = 0…len-1 on consecutive cycles.
  - Addresses are `a_base+i` and `b_base+i`, modulo 2^ADDR_WIDTH (wrap, no error).
  - After the read for i = len-1, go to DRAIN.
- **Operand register:**
  - Each returned pair is registered into `mac_a`/`mac_b` on the clock after the data returns.
  - `mac_rst` goes to 1 in the same cycle that pair 0 appears on `mac_a`/`mac_b`.
- **DRAIN:** lasts until pair len-1 has been presented, then go to WAIT.
- **WAIT:**
  - `mac_a` = `mac_b` = 16'h0000 (+0.0), so extra MAC cycles add nothing.
  - A timeout counter increments each cycle.
  - `mac_result_ready`=1 → `out_data` ← `mac_result`, `mac_rst` ← 0, go to HOLD.
  - Counter reaches `TIMEOUT` first → `err_timeout` ← 1, `out_data` ← 16'h7E00 (qNaN), `mac_rst` ← 0, go to HOLD.
- **HOLD:**
  - `out_valid`=1, and `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid`=1 and `out_ready`=1 → go to IDLE next cycle, `out_valid` ← 0.
- **Start while busy:** `start` is ignored in any state other than IDLE; no queuing.
- **Reset mid-job:** asserting `rst` in any state aborts immediately to the reset values above. No partial result is emitted.

## Timing
Start accepted at the edge ending cycle T:
- **Reads:** `a_rd_en`/`b_rd_en` high in cycles T+1…T+len.
- **Read data:** valid in cycles T+2…T+len+1.
- **MAC operands and reset:** operand pair i is on `mac_a`/`mac_b` in cycle T+3+i. `mac_rst`=1 from cycle T+3.
- **WAIT:** entered in cycle T+len+3.
- **Result capture:** a `mac_result_ready` pulse in cycle W is captured at the edge ending W. `out_valid`=1 from cycle W+1 and `mac_rst`=0 from cycle W+1.
- **Back-to-back jobs:** the minimum gap between accepted starts is len+5 cycles plus MAC latency plus stall cycles.
- **Handshake:** a transfer occurs on a cycle with `out_valid`=1 and `out_ready`=1. `out_ready` may be high before `out_valid`; no combinational path from `out_ready` to `out_valid`.
- **Same-cycle events:**
  - A ready pulse and timeout expiry in the same cycle: the ready pulse wins, and `err_timeout` stays 0.
  - A `mac_result_ready` pulse outside WAIT is ignored.

## Test plan
- **Basic job:** `len`=4, `a_base`=0, `b_base`=16; buffers hold a={1.0,2.0,3.0,4.0} and b={1.0,1.0,0.5,2.0} (0x3C00…). Require reads at addresses 0–3 and 16–19, pair 0 on the MAC 3 cycles after start, and `out_data`=0x4A40 (12.5).
- **Backpressure:** basic job with `out_ready`=0 for 3 cycles after `out_valid` rises. Require `out_data` stable for those 3 cycles, a single transfer, return to IDLE, and `busy`=0 on the following cycle.
- **Zero length and start while busy:** `len`=0 → `out_valid` with `out_data`=0x0000, no `rd_en` pulses, `mac_rst` held 0. A second `start` pulsed during FETCH is ignored: exactly one result.
- **Address wrap:** `a_base`=1022, `len`=4. Require `a_rd_addr` sequence 1022, 1023, 0, 1.
- **Timeout:** MAC model never asserts `mac_result_ready`. After `TIMEOUT` WAIT cycles require `err_timeout`=1 and `out_data`=0x7E00; the next accepted start clears `err_timeout`.
- **Reset mid-job:** drive `rst`=0 for 1 cycle during WAIT. Require all outputs at reset values immediately, no `out_valid`, and a correct result from the following job.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Operand sequencer for one FP16 MAC lane: streams len operand pairs from two
// synchronous-read buffers, gates the MAC reset per job, returns the result on valid/ready.
module mac_operand_feeder #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int CLK_NUM_WIDTH = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CLK_NUM_WIDTH-1:0] len,
  input  logic [ADDR_WIDTH-1:0]    a_base,
  input  logic [ADDR_WIDTH-1:0]    b_base,
  output logic                     busy,
  output logic                     a_rd_en,
  output logic                     b_rd_en,
  output logic [ADDR_WIDTH-1:0]    a_rd_addr,
  output logic [ADDR_WIDTH-1:0]    b_rd_addr,
  input  logic [DATA_WIDTH-1:0]    a_rd_data,
  input  logic [DATA_WIDTH-1:0]    b_rd_data,
  output logic                     mac_rst,
  output logic [DATA_WIDTH-1:0]    mac_a,
  output logic [DATA_WIDTH-1:0]    mac_b,
  output logic [CLK_NUM_WIDTH-1:0] mac_clk_num,
  input  logic                     mac_result_ready,
  input  logic [DATA_WIDTH-1:0]    mac_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT, HOLD} state_t;

  state_t                   state, state_nxt;
  logic [CLK_NUM_WIDTH-1:0] len_q, idx;
  logic [TW-1:0]            tmo_cnt;
  logic                     data_vld;   // buffer read data valid this cycle
  logic                     tmo_hit;

  assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));
  assign busy        = (state != IDLE);
  assign a_rd_en     = (state == FETCH);
  assign b_rd_en     = (state == FETCH);
  assign out_valid   = (state == HOLD);
  assign mac_clk_num = len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (len != '0) ? FETCH : HOLD;
      FETCH: if (idx == len_q - CLK_NUM_WIDTH'(1)) state_nxt = DRAIN;
      // last pair reaches the MAC the cycle after its read data stops
      DRAIN: if (!data_vld) state_nxt = WAIT;
      WAIT:  if (mac_result_ready || tmo_hit) state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      data_vld    <= 1'b0;
      a_rd_addr   <= '0;
      b_rd_addr   <= '0;
      mac_a       <= '0;
      mac_b       <= '0;
      mac_rst     <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      data_vld <= (state == FETCH);
      // zero operands outside the stream keep extra MAC cycles neutral
      if (data_vld) begin
        mac_a   <= a_rd_data;
        mac_b   <= b_rd_data;
        mac_rst <= 1'b1;
      end else begin
        mac_a <= '0;
        mac_b <= '0;
      end
      case (state)
        IDLE: if (start) begin
          if (len != '0) begin
            len_q       <= len;
            a_rd_addr   <= a_base;
            b_rd_addr   <= b_base;
            idx         <= '0;
            err_timeout <= 1'b0;
          end else begin
            out_data <= '0;
          end
        end
        FETCH: begin
          idx       <= idx + CLK_NUM_WIDTH'(1);
          a_rd_addr <= a_rd_addr + ADDR_WIDTH'(1);
          b_rd_addr <= b_rd_addr + ADDR_WIDTH'(1);
        end
        DRAIN: tmo_cnt <= '0;
        WAIT: begin
          // result pulse wins over a same-cycle timeout
          if (mac_result_ready) begin
            out_data <= mac_result;
            mac_rst  <= 1'b0;
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            out_data    <= DATA_WIDTH'(16'h7E00);
            mac_rst     <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: buffer and MAC models, a vector table of
// jobs, and hand sequences for reset-at-power-up and reset mid-job.
module tb_mac_operand_feeder;
  localparam int TIMEOUT = 64;
  localparam int NV      = 9;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start, busy, a_rd_en, b_rd_en, mac_rst, mac_result_ready;
  logic        out_valid, out_ready, err_timeout;
  logic [7:0]  len, mac_clk_num;
  logic [9:0]  a_base, b_base, a_rd_addr, b_rd_addr;
  logic [15:0] a_rd_data, b_rd_data, mac_a, mac_b, mac_result, out_data;

  always #5 clk = ~clk;

  mac_operand_feeder #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CLK_NUM_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .a_base(a_base), .b_base(b_base),
    .busy(busy), .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .mac_rst(mac_rst), .mac_a(mac_a), .mac_b(mac_b),
    .mac_clk_num(mac_clk_num), .mac_result_ready(mac_result_ready), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_timeout(err_timeout));

  // synchronous-read buffers
  logic [15:0] amem [1024];
  logic [15:0] bmem [1024];
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
  end

  // MAC model: pulses mac_resp once, len+mac_lat cycles after its reset releases
  int          mac_cnt, mac_lat;
  logic [15:0] mac_resp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_cnt <= 0; mac_result_ready <= 1'b0; mac_result <= '0;
    end else begin
      mac_result_ready <= 1'b0;
      if (!mac_rst) mac_cnt <= 0;
      else begin
        mac_cnt <= mac_cnt + 1;
        if (mac_cnt == int'(mac_clk_num) + mac_lat) begin
          mac_result_ready <= 1'b1;
          mac_result       <= mac_resp;
        end
      end
    end
  end

  // observation logs, sampled on the falling edge
  int          cyc = 0;
  logic [9:0]  rd_a_q[$], rd_b_q[$];
  int          rd_cyc_q[$];
  logic [15:0] op_a_q[$], op_b_q[$];
  int          rst_rise_cyc, ov_rise_cyc, xfer_cnt;
  logic        mac_rst_d = 1'b0, ov_d = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (a_rd_en) begin rd_a_q.push_back(a_rd_addr); rd_cyc_q.push_back(cyc); end
    if (b_rd_en) rd_b_q.push_back(b_rd_addr);
    if (mac_rst) begin
      op_a_q.push_back(mac_a); op_b_q.push_back(mac_b);
      if (!mac_rst_d) rst_rise_cyc = cyc;
    end
    if (out_valid && !ov_d) ov_rise_cyc = cyc;
    if (out_valid && out_ready) xfer_cnt++;
    mac_rst_d = mac_rst;
    ov_d      = out_valid;
  end

  typedef struct {
    logic [7:0]  len;
    logic [9:0]  a_base, b_base;
    int          lat;
    logic [15:0] resp;
    int          stall;
    bit          busy_start;
    logic [15:0] exp_data;
    bit          exp_err;
  } vec_t;
  vec_t tbl [NV];

  int n_chk = 0, n_fail = 0;
  bit prev_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    rd_a_q.delete(); rd_b_q.delete(); rd_cyc_q.delete(); op_a_q.delete(); op_b_q.delete();
    rst_rise_cyc = -1; ov_rise_cyc = -1; xfer_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {busy, a_rd_en, b_rd_en, mac_rst, out_valid, err_timeout, a_rd_addr, b_rd_addr}, 64'd0);
    check({tag, "_data"}, {mac_a, mac_b, mac_clk_num, out_data}, 64'd0);
  endtask

  task automatic run_job(input int k);
    vec_t v;
    int t0, n, exp_ov;
    logic [9:0] ea, eb;
    v = tbl[k];
    clear_logs();
    check($sformatf("v%0d_err_before", k), err_timeout, prev_err);
    mac_lat = v.lat; mac_resp = v.resp; out_ready = (v.stall == 0);
    start = 1'b1; len = v.len; a_base = v.a_base; b_base = v.b_base; t0 = cyc;
    @(negedge clk); start = 1'b0;
    check($sformatf("v%0d_busy", k), busy, 1);
    check($sformatf("v%0d_first_rd_en", k), a_rd_en, v.len != 0);
    if (v.len != 0) check($sformatf("v%0d_clk_num", k), mac_clk_num, v.len);
    if (v.busy_start) begin
      @(negedge clk); start = 1'b1; len = 8'd1;
      @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    check($sformatf("v%0d_valid_seen", k), out_valid, 1);
    check($sformatf("v%0d_out_data", k), out_data, v.exp_data);
    check($sformatf("v%0d_err", k), err_timeout, v.exp_err);
    for (int s = 1; s <= v.stall; s++) begin
      @(negedge clk);
      check($sformatf("v%0d_hold%0d", k, s), {out_valid, out_data}, {1'b1, v.exp_data});
      if (s == v.stall) out_ready = 1'b1;
    end
    @(negedge clk);
    check($sformatf("v%0d_post_xfer", k), {out_valid, busy}, 2'b00);
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_xfer_cnt", k), xfer_cnt, 1);
    check($sformatf("v%0d_idle", k), busy, 0);
    check($sformatf("v%0d_rd_cnt", k), {rd_a_q.size(), rd_b_q.size()}, {int'(v.len), int'(v.len)});
    for (int i = 0; i < int'(v.len) && i < rd_a_q.size() && i < rd_b_q.size(); i++) begin
      ea = v.a_base + 10'(i);
      eb = v.b_base + 10'(i);
      check($sformatf("v%0d_rd%0d", k, i), {rd_a_q[i], rd_b_q[i], rd_cyc_q[i]}, {ea, eb, t0 + 1 + i});
    end
    if (v.len == 0) begin
      check($sformatf("v%0d_no_mac", k), rst_rise_cyc, -1);
      check($sformatf("v%0d_no_ops", k), op_a_q.size(), 0);
    end else begin
      check($sformatf("v%0d_mac_rst_rise", k), rst_rise_cyc, t0 + 3);
      check($sformatf("v%0d_op_cnt", k), op_a_q.size() > int'(v.len), 1);
      for (int i = 0; i < int'(v.len) && i < op_a_q.size(); i++) begin
        ea = v.a_base + 10'(i);
        eb = v.b_base + 10'(i);
        check($sformatf("v%0d_op%0d", k, i), {op_a_q[i], op_b_q[i]}, {amem[ea], bmem[eb]});
      end
      if (op_a_q.size() > int'(v.len))
        check($sformatf("v%0d_wait_zero", k), {op_a_q[v.len], op_b_q[v.len]}, 32'd0);
    end
    exp_ov = (v.len == 0) ? t0 + 1 :
             v.exp_err    ? t0 + int'(v.len) + 3 + TIMEOUT : t0 + int'(v.len) + 5 + v.lat;
    check($sformatf("v%0d_valid_cycle", k), ov_rise_cyc - t0, exp_ov - t0);
    if (v.len != 0) prev_err = v.exp_err;
  endtask

  initial begin
    //             len    a_base   b_base   lat resp      stall busy  exp_data  err
    tbl[0] = '{8'd4,   10'd0,   10'd16,   2, 16'h4A40, 0, 1'b0, 16'h4A40, 1'b0}; // basic, 12.5
    tbl[1] = '{8'd4,   10'd0,   10'd16,   2, 16'h4A40, 3, 1'b0, 16'h4A40, 1'b0}; // backpressure
    tbl[2] = '{8'd0,   10'd0,   10'd0,    0, 16'h1111, 0, 1'b0, 16'h0000, 1'b0}; // zero length
    tbl[3] = '{8'd4,   10'd1022, 10'd1023, 1, 16'h4200, 0, 1'b0, 16'h4200, 1'b0}; // address wrap
    tbl[4] = '{8'd6,   10'd100, 10'd200,  3, 16'hC500, 0, 1'b1, 16'hC500, 1'b0}; // start while busy
    tbl[5] = '{8'd3,   10'd10,  10'd20,  62, 16'h3C00, 0, 1'b0, 16'h3C00, 1'b0}; // ready ties timeout
    tbl[6] = '{8'd2,   10'd30,  10'd40,  63, 16'h1234, 3, 1'b0, 16'h7E00, 1'b1}; // timeout, late pulse in HOLD
    tbl[7] = '{8'd1,   10'd50,  10'd60,   0, 16'h4000, 0, 1'b0, 16'h4000, 1'b0}; // clears err_timeout
    tbl[8] = '{8'd255, 10'd900, 10'd0,    5, 16'h5555, 1, 1'b0, 16'h5555, 1'b0}; // max length, wraps
    for (int i = 0; i < 1024; i++) begin
      amem[i] = 16'h1000 + 16'(i);
      bmem[i] = 16'h8000 | 16'(i * 3);
    end
    amem[0] = 16'h3C00; amem[1] = 16'h4000; amem[2] = 16'h4200; amem[3] = 16'h4400;
    bmem[16] = 16'h3C00; bmem[17] = 16'h3C00; bmem[18] = 16'h3800; bmem[19] = 16'h4000;
    start = 1'b0; len = '0; a_base = '0; b_base = '0; out_ready = 1'b0;
    mac_lat = 0; mac_resp = '0;
    clear_logs();

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NV; k++) run_job(k);

    // reset pulse while waiting on the MAC
    clear_logs();
    mac_lat = 10; mac_resp = 16'hBEEF; out_ready = 1'b1;
    start = 1'b1; len = 8'd4; a_base = 10'd5; b_base = 10'd7;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("midjob_in_wait", {busy, a_rd_en, mac_rst, mac_a, mac_b}, {1'b1, 1'b0, 1'b1, 32'd0});
    rst = 1'b0;
    #1 check_reset("midjob");
    @(negedge clk); rst = 1'b1;
    prev_err = 1'b0;
    repeat (20) @(negedge clk);
    check("midjob_no_valid", ov_rise_cyc, -1);
    check("midjob_no_xfer", xfer_cnt, 0);
    check("midjob_idle", busy, 0);
    run_job(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
